fft64_twiddle_seq: RTL

Twiddle address sequencer for the 64-point radix-2^2 SDF FFT pipeline. It tracks valid samples entering the FFT and produces, for each of the two twiddle multipliers, a 6-bit twiddle address and enable. Each address is aligned to the multiplier input, accounting for butterfly latency and the registered twiddle table. It sits beside the datapath and drives the address inputs of both 64-entry twiddle table instances (TW_FF=1).

---
 rtl/fft64_twiddle_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fft64_twiddle_seq.sv
// fft64_twiddle_seq
// Twiddle address sequencer for a 64-point radix-2^2 SDF FFT. It tracks the
// valid samples entering the pipeline. For each of the two twiddle multipliers
// it issues a 6-bit table address and an enable. Each address is timed so that
// the registered twiddle table output meets the sample at the multiplier input.
module fft64_twiddle_seq #(
   parameter int LAT1 = 50,   // di_en -> multiplier 1 input, >= 2
   parameter int LAT2 = 14    // multiplier 1 input -> multiplier 2 input, >= 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       di_en,
   input  logic       sync,
   output logic [5:0] tw_addr1,
   output logic       tw_en1,
   output logic [5:0] tw_addr2,
   output logic       tw_en2,
   output logic       frame_done,
   output logic       busy
);

   // The output register is the last stage of the multiplier 1 delay.
   // Only LAT1-2 shift stages sit in front of it.
   localparam int D1 = LAT1 - 2;

   // Maps a group to its multiplier. The groups come in bit-reversed order.
   function automatic logic [1:0] grp_mult_f(input logic [1:0] g);
      logic [1:0] r;
      case (g)
         2'd0:    r = 2'd0;
         2'd1:    r = 2'd2;
         2'd2:    r = 2'd1;
         2'd3:    r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   // Multiplier 1 address is k * mult(g), with k = idx[3:0] and g = idx[5:4].
   // The largest value is 15 * 3 = 45.
   function automatic logic [5:0] addr1_f(input logic [5:0] idx);
      return {2'b00, idx[3:0]} * {4'b0000, grp_mult_f(idx[5:4])};
   endfunction

   // Multiplier 2 address is 4 * k * mult(g), with k = idx[1:0] and g = idx[3:2].
   // The largest value is 4 * 3 * 3 = 36.
   function automatic logic [5:0] addr2_f(input logic [3:0] idx);
      return {2'b00, idx[1:0], 2'b00} * {4'b0000, grp_mult_f(idx[3:2])};
   endfunction

   logic e1_s, s1_s, dl1_any_s;
   logic e2_s, s2_s;

   generate
      if (D1 > 0) begin : g_dl1
         logic [D1-1:0] en_q;
         logic [D1-1:0] sy_q;

         // Carries the sample strobe and the qualified sync toward multiplier 1.
         always_ff @(posedge clock) begin
            if (reset) begin
               en_q <= {D1{1'b0}};
               sy_q <= {D1{1'b0}};
            end else begin
               en_q <= D1'({en_q, di_en});
               sy_q <= D1'({sy_q, di_en & sync});
            end
         end

         assign e1_s      = en_q[D1-1];
         assign s1_s      = sy_q[D1-1];
         assign dl1_any_s = |en_q;
      end else begin : g_nodl1
         assign e1_s      = di_en;
         assign s1_s      = di_en & sync;
         assign dl1_any_s = 1'b0;
      end
   endgenerate

   logic [LAT2-1:0] dl2_en_q;
   logic [LAT2-1:0] dl2_sy_q;

   // Carries the multiplier 1 strobes on by LAT2 cycles to multiplier 2.
   always_ff @(posedge clock) begin
      if (reset) begin
         dl2_en_q <= {LAT2{1'b0}};
         dl2_sy_q <= {LAT2{1'b0}};
      end else begin
         dl2_en_q <= LAT2'({dl2_en_q, e1_s});
         dl2_sy_q <= LAT2'({dl2_sy_q, s1_s});
      end
   end

   assign e2_s = dl2_en_q[LAT2-1];
   assign s2_s = dl2_sy_q[LAT2-1];

   logic [5:0] n_q, n_d, m_q, m_d;
   logic [5:0] idx1_s, idx2_s;
   logic [5:0] tw_addr1_q, tw_addr1_d, tw_addr2_q, tw_addr2_d;
   logic       tw_en1_q, tw_en2_q;
   logic       frame_done_q, frame_done_d;
   logic       busy_q, busy_d;

   // Computes the sample indices, the next counter values and the next outputs.
   always_comb begin
      idx1_s       = s1_s ? 6'd0 : n_q;
      idx2_s       = s2_s ? 6'd0 : m_q;
      n_d          = n_q;
      m_d          = m_q;
      tw_addr1_d   = 6'd0;
      tw_addr2_d   = 6'd0;
      frame_done_d = 1'b0;
      if (e1_s) begin
         n_d        = idx1_s + 6'd1;
         tw_addr1_d = addr1_f(idx1_s);
      end else begin
         n_d        = n_q;
         tw_addr1_d = 6'd0;
      end
      if (e2_s) begin
         m_d          = idx2_s + 6'd1;
         tw_addr2_d   = addr2_f(idx2_s[3:0]);
         frame_done_d = (idx2_s == 6'd63);
      end else begin
         m_d          = m_q;
         tw_addr2_d   = 6'd0;
         frame_done_d = 1'b0;
      end
      busy_d = dl1_any_s | (|dl2_en_q) | e1_s | e2_s
               | (n_q != 6'd0) | (m_q != 6'd0);
   end

   // Holds the counters and the registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         n_q          <= 6'd0;
         m_q          <= 6'd0;
         tw_addr1_q   <= 6'd0;
         tw_addr2_q   <= 6'd0;
         tw_en1_q     <= 1'b0;
         tw_en2_q     <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         n_q          <= n_d;
         m_q          <= m_d;
         tw_addr1_q   <= tw_addr1_d;
         tw_addr2_q   <= tw_addr2_d;
         tw_en1_q     <= e1_s;
         tw_en2_q     <= e2_s;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign tw_addr1   = tw_addr1_q;
   assign tw_en1     = tw_en1_q;
   assign tw_addr2   = tw_addr2_q;
   assign tw_en2     = tw_en2_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule
